// File: rtl/entropy_ctrl_pkg.sv
// Shared definitions for the entropy encoder control blocks: sequencer state
// encoding and the range value loaded at reset and at the end of every frame.
package entropy_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_FLUSH = 3'd4
    } seq_state_t;

    localparam logic [15:0] RANGE_INIT = 16'h8000;

endpackage

// File: rtl/sat_accumulator.sv
// Accumulator that clamps at all-ones instead of wrapping; used for the
// per-frame symbol and bit statistics of the sequencer.
module sat_accumulator #(
    parameter int WIDTH     = 32,
    parameter int ADD_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 add_en,
    input  logic [ADD_WIDTH-1:0] add_val,
    output logic [WIDTH-1:0]     value
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH:0]   sum;

    // One spare bit catches the carry out that signals saturation.
    assign sum = {1'b0, acc_q} + (WIDTH+1)'(add_val);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc_q <= '0;
        end else if (add_en) begin
            acc_q <= sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        end
    end

    assign value = acc_q;

endmodule

// File: rtl/encoder_symbol_sequencer.sv
// Issues one symbol at a time to the stage_1/stage_2 datapath, feeds the
// normalized range back as the next in_range, and requests a flush at frame end.
module encoder_symbol_sequencer
    import entropy_ctrl_pkg::*;
#(
    parameter int RANGE_WIDTH  = 16,
    parameter int D_SIZE       = 5,
    parameter int SYMBOL_WIDTH = 4,
    parameter int FB_TIMEOUT   = 15,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [RANGE_WIDTH-1:0]  s_fl,
    input  logic [RANGE_WIDTH-1:0]  s_fh,
    input  logic [SYMBOL_WIDTH-1:0] s_symbol,
    input  logic                    s_bool,
    input  logic                    s_last,
    output logic                    m_valid,
    output logic [RANGE_WIDTH-1:0]  m_fl,
    output logic [RANGE_WIDTH-1:0]  m_fh,
    output logic [SYMBOL_WIDTH-1:0] m_symbol,
    output logic                    m_bool,
    output logic [RANGE_WIDTH-1:0]  m_range,
    input  logic                    fb_valid,
    input  logic [RANGE_WIDTH-1:0]  fb_range,
    input  logic [D_SIZE-1:0]       fb_d,
    output logic                    flush_req,
    input  logic                    flush_ack,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    sym_count,
    output logic [CNT_WIDTH-1:0]    bit_count,
    output logic                    err_timeout,
    output logic                    err_proto,
    output logic [2:0]              fsm_state
);

    localparam int TW = $clog2(FB_TIMEOUT + 1);
    localparam logic [RANGE_WIDTH-1:0] RANGE_INIT_W = RANGE_WIDTH'(RANGE_INIT);

    seq_state_t    state;
    logic          last_q;
    logic [TW-1:0] tmo_cnt;
    logic [TW:0]   tmo_next;
    logic          acc_add;
    logic          acc_clear;

    assign tmo_next  = {1'b0, tmo_cnt} + 1'b1;
    assign acc_add   = (state == ST_WAIT) && fb_valid;
    assign acc_clear = (state == ST_FLUSH) && flush_ack;
    assign fsm_state = state;

    // Upstream transfer: s_valid && s_ready at a rising edge; s_ready is only high
    // in IDLE/READY, and upstream must hold its data steady while s_ready is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            s_ready     <= 1'b1;
            busy        <= 1'b0;
            m_valid     <= 1'b0;
            flush_req   <= 1'b0;
            m_fl        <= '0;
            m_fh        <= '0;
            m_symbol    <= '0;
            m_bool      <= 1'b0;
            m_range     <= RANGE_INIT_W;
            last_q      <= 1'b0;
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
            err_proto   <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            if (fb_valid && state != ST_WAIT) begin
                err_proto <= 1'b1;
            end
            case (state)
                ST_IDLE, ST_READY: begin
                    if (s_valid) begin
                        m_fl     <= s_fl;
                        m_fh     <= s_fh;
                        m_symbol <= s_symbol;
                        m_bool   <= s_bool;
                        last_q   <= s_last;
                        m_valid  <= 1'b1;
                        s_ready  <= 1'b0;
                        busy     <= 1'b1;
                        tmo_cnt  <= '0;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    // A result arriving on the timeout cycle still counts as on time.
                    if (fb_valid) begin
                        m_range <= fb_range;
                        if (!fb_range[RANGE_WIDTH-1]) begin
                            err_proto <= 1'b1;
                        end
                        if (last_q) begin
                            flush_req <= 1'b1;
                            state     <= ST_FLUSH;
                        end else begin
                            s_ready <= 1'b1;
                            state   <= ST_READY;
                        end
                    end else if (tmo_next == (TW+1)'(FB_TIMEOUT)) begin
                        err_timeout <= 1'b1;
                        s_ready     <= 1'b1;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_next[TW-1:0];
                    end
                end
                ST_FLUSH: begin
                    if (flush_ack) begin
                        m_range   <= RANGE_INIT_W;
                        flush_req <= 1'b0;
                        s_ready   <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    s_ready   <= 1'b1;
                    busy      <= 1'b0;
                    flush_req <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    sat_accumulator #(.WIDTH(CNT_WIDTH), .ADD_WIDTH(1)) u_sym_acc (
        .clk     (clk),
        .reset   (reset),
        .clear   (acc_clear),
        .add_en  (acc_add),
        .add_val (1'b1),
        .value   (sym_count)
    );

    sat_accumulator #(.WIDTH(CNT_WIDTH), .ADD_WIDTH(D_SIZE)) u_bit_acc (
        .clk     (clk),
        .reset   (reset),
        .clear   (acc_clear),
        .add_en  (acc_add),
        .add_val (fb_d),
        .value   (bit_count)
    );

endmodule
